// File: rtl/phaser_pkg.sv
// Shared types and constants for the phaser shift scheduler.
// Used by phaser_sched and phaser_rr_arb.
package phaser_pkg;

  localparam int MXCH_DEF    = 3;
  localparam int MXPHASE_DEF = 6;

  localparam logic [2:0] PH_SM_UNFIRE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_FIRE      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

endpackage

// File: rtl/phaser_rr_arb.sv
// Round-robin priority encoder over pending phaser channels.
// Search starts one past cur_ch and wraps; nearest pending wins.
module phaser_rr_arb #(
  parameter int NCH  = 7,
  parameter int MXCH = 3
) (
  input  logic [NCH-1:0]  pending,
  input  logic [MXCH-1:0] cur_ch,
  output logic [MXCH-1:0] winner,
  output logic            valid
);

  logic [MXCH-1:0] idx;

  // Walk from farthest to nearest so the nearest hit overrides.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = MXCH'((int'(cur_ch) + k) % NCH);
      if (pending[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phaser_sched.sv
// Serialising scheduler for the DCM phase-shift state machines.
// Optional PROM autoload of targets: define PHASER_SCHED_AUTOLOAD_EN.
module phaser_sched
  import phaser_pkg::*;
#(
  parameter int NCH     = 7,
  parameter int MXCH    = MXCH_DEF,
  parameter int MXPHASE = MXPHASE_DEF,
  parameter int MXTMO   = 12
) (
  input  logic                   clock,
  input  logic                   global_reset_n,
  input  logic                   wr_en,
  input  logic [MXCH-1:0]        wr_ch,
  input  logic [MXPHASE-1:0]     wr_phase,
  input  logic [NCH-1:0]         ph_busy,
  input  logic [3*NCH-1:0]       ph_sm_vec,
  output logic [NCH-1:0]         ph_fire,
  output logic [NCH*MXPHASE-1:0] ph_phase,
  output logic                   sched_busy,
  output logic [MXCH-1:0]        cur_ch,
  output logic [NCH-1:0]         pending,
  output logic [NCH-1:0]         tmo_err
`ifdef PHASER_SCHED_AUTOLOAD_EN
  ,
  input  logic                   lock_tmb,
  input  logic [NCH*MXPHASE-1:0] autoload_phase
`endif
);

  state_t             state;
  state_t             state_nxt;
  logic [MXTMO-1:0]   tmo_cnt;
  logic [MXPHASE-1:0] target [NCH];
  logic [NCH-1:0]     pending_nxt;
  logic [MXCH-1:0]    win_ch;
  logic               win_vld;
  logic               wr_hit;
  logic               al_fire;
  logic               tmo_sat;
  logic               tmo_hit;
  logic               busy_cur;
  logic [2:0]         sm_cur;

  assign wr_hit   = wr_en && (int'(wr_ch) < NCH);
  assign tmo_sat  = &tmo_cnt;
  assign busy_cur = ph_busy[cur_ch];
  assign sm_cur   = ph_sm_vec[cur_ch*3 +: 3];

`ifdef PHASER_SCHED_AUTOLOAD_EN
  logic al_done;

  assign al_fire = lock_tmb && !al_done;

  // First lock after reset triggers a single autoload.
  always_ff @(posedge clock) begin
    if (!global_reset_n) al_done <= 1'b0;
    else if (lock_tmb)   al_done <= 1'b1;
  end
`else
  assign al_fire = 1'b0;
`endif

  phaser_rr_arb #(
    .NCH  (NCH),
    .MXCH (MXCH)
  ) u_arb (
    .pending (pending),
    .cur_ch  (cur_ch),
    .winner  (win_ch),
    .valid   (win_vld)
  );

  // Next state; any wait that saturates the timer bails to idle.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    unique case (state)
      S_IDLE: if (|pending) state_nxt = S_ARB;
      S_ARB:  state_nxt = win_vld ? S_FIRE : S_IDLE;
      S_FIRE: state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (busy_cur)     state_nxt = S_WAIT_DONE;
        else if (tmo_sat) tmo_hit   = 1'b1;
      end
      S_WAIT_DONE: begin
        if (sm_cur == PH_SM_UNFIRE) state_nxt = S_WAIT_IDLE;
        else if (tmo_sat)           tmo_hit   = 1'b1;
      end
      S_WAIT_IDLE: begin
        if (!busy_cur)    state_nxt = S_IDLE;
        else if (tmo_sat) tmo_hit   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) state_nxt = S_IDLE;
  end

  // Pending: arb clears its winner, autoload then writes set.
  always_comb begin
    pending_nxt = pending;
    if (state == S_ARB && win_vld) pending_nxt[win_ch] = 1'b0;
    if (al_fire) pending_nxt = '1;
    if (wr_hit)  pending_nxt[wr_ch] = 1'b1;
  end

  // Target phase registers, loaded by VME or autoload.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (!global_reset_n)
        target[i] <= '0;
      else if (wr_hit && wr_ch == MXCH'(i))
        target[i] <= wr_phase;
      else if (al_fire)
        target[i] <= autoload_sel(i);
    end
  end

  function automatic logic [MXPHASE-1:0] autoload_sel(input int i);
`ifdef PHASER_SCHED_AUTOLOAD_EN
    return autoload_phase[i*MXPHASE +: MXPHASE];
`else
    return target[i];
`endif
  endfunction

  // Scheduler state, timer, channel selection and phaser drive.
  always_ff @(posedge clock) begin
    if (!global_reset_n) begin
      state      <= S_IDLE;
      sched_busy <= 1'b0;
      tmo_cnt    <= '0;
      pending    <= '0;
      tmo_err    <= '0;
      cur_ch     <= MXCH'(NCH - 1);
      ph_fire    <= '0;
      ph_phase   <= '0;
    end else begin
      state      <= state_nxt;
      sched_busy <= (state_nxt != S_IDLE);
      pending    <= pending_nxt;
      if (state_nxt != state) tmo_cnt <= '0;
      else if (!tmo_sat)      tmo_cnt <= tmo_cnt + MXTMO'(1);
      if (state == S_ARB && win_vld) begin
        cur_ch  <= win_ch;
        ph_fire <= NCH'(1) << win_ch;
        ph_phase[win_ch*MXPHASE +: MXPHASE] <= target[win_ch];
      end
      if (state == S_WAIT_DONE && state_nxt == S_WAIT_IDLE)
        ph_fire <= '0;
      if (tmo_hit) begin
        ph_fire         <= '0;
        tmo_err[cur_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phaser_sched.sv
// Directed bench for phaser_sched with a simple phaser model.
// Autoload scenario runs when PHASER_SCHED_AUTOLOAD_EN is defined.
module tb_phaser_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [5:0]  wr_phase;
  logic [6:0]  ph_busy;
  logic [20:0] ph_sm_vec;
  logic [6:0]  ph_fire;
  logic [41:0] ph_phase;
  logic        sched_busy;
  logic [2:0]  cur_ch;
  logic [6:0]  pending;
  logic [6:0]  tmo_err;
`ifdef PHASER_SCHED_AUTOLOAD_EN
  logic        lock_tmb;
  logic [41:0] autoload_phase;
`endif

  int checks   = 0;
  int failures = 0;

  int         mst  [7];
  int         mcnt [7];
  bit         dead [7];
  logic [6:0] fire_q;
  logic [20:0] sm_q;
  int         onehot_bad;
  int         drop_bad;
  int         order  [$];
  int         ph_at  [$];
  logic [6:0] pend_at[$];

  always #5 clk = ~clk;

  phaser_sched dut (
    .clock          (clk),
    .global_reset_n (rst_n),
    .wr_en          (wr_en),
    .wr_ch          (wr_ch),
    .wr_phase       (wr_phase),
    .ph_busy        (ph_busy),
    .ph_sm_vec      (ph_sm_vec),
    .ph_fire        (ph_fire),
    .ph_phase       (ph_phase),
    .sched_busy     (sched_busy),
    .cur_ch         (cur_ch),
    .pending        (pending),
    .tmo_err        (tmo_err)
`ifdef PHASER_SCHED_AUTOLOAD_EN
    ,
    .lock_tmb       (lock_tmb),
    .autoload_phase (autoload_phase)
`endif
  );

  // Phaser model: busy 1 cycle after fire, unfire state a few
  // cycles later, back to idle once fire drops.
  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      if (!rst_n) begin
        mst[i] <= 0;
        mcnt[i] <= 0;
        ph_busy[i] <= 1'b0;
        ph_sm_vec[3*i +: 3] <= 3'd0;
      end else if (!dead[i]) begin
        case (mst[i])
          0: if (ph_fire[i]) mst[i] <= 1;
          1: begin
            ph_busy[i] <= 1'b1;
            mcnt[i] <= 0;
            mst[i] <= 2;
          end
          2: begin
            if (mcnt[i] == 3) begin
              ph_sm_vec[3*i +: 3] <= 3'd6;
              mst[i] <= 3;
            end else mcnt[i] <= mcnt[i] + 1;
          end
          default: if (!ph_fire[i]) begin
            ph_busy[i] <= 1'b0;
            ph_sm_vec[3*i +: 3] <= 3'd0;
            mst[i] <= 0;
          end
        endcase
      end
    end
  end

  // Monitor: log each fire rise, flag non-one-hot fire and
  // fire dropping before the unfire state was shown.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(ph_fire)) onehot_bad++;
      for (int i = 0; i < 7; i++) begin
        if (ph_fire[i] && !fire_q[i]) begin
          order.push_back(i);
          ph_at.push_back(int'(ph_phase[6*i +: 6]));
          pend_at.push_back(pending);
        end
        if (!ph_fire[i] && fire_q[i] && !dead[i]
            && sm_q[3*i +: 3] != 3'd6)
          drop_bad++;
      end
    end
    fire_q = ph_fire;
    sm_q   = ph_sm_vec;
  end

  task automatic vme_wr(input int ch, input int ph);
    wr_en    = 1'b1;
    wr_ch    = 3'(ch);
    wr_phase = 6'(ph);
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic wait_quiet(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (!sched_busy && pending == 7'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    order.delete();
    ph_at.delete();
    pend_at.delete();
    onehot_bad = 0;
    drop_bad   = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ph_fire, pending, tmo_err, sched_busy} !== 22'd0) begin
      failures++;
      $display("FAIL reset_flags got=%h exp=0",
               {ph_fire, pending, tmo_err, sched_busy});
    end
    checks++;
    if (ph_phase !== 42'd0) begin
      failures++;
      $display("FAIL reset_phase got=%h exp=0", ph_phase);
    end
    checks++;
    if (cur_ch !== 3'd6) begin
      failures++;
      $display("FAIL reset_cur_ch got=%0d exp=6", cur_ch);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0", sched_busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_log();
    vme_wr(2, 40);
    checks++;
    if (pending !== 7'h04) begin
      failures++;
      $display("FAIL single_pend got=%h exp=04", pending);
    end
    wait_quiet(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_done got=busy exp=idle");
    end
    checks++;
    if (order.size() != 1 || order[0] != 2 || ph_at[0] != 40) begin
      failures++;
      $display("FAIL single_fire got=n%0d ch%0d ph%0d exp=n1 ch2 ph40",
               order.size(), order[0], ph_at[0]);
    end
    checks++;
    if (pend_at[0] !== 7'h00) begin
      failures++;
      $display("FAIL single_arb_clr got=%h exp=00", pend_at[0]);
    end
    checks++;
    if (ph_phase[17:12] !== 6'd40 || cur_ch !== 3'd2) begin
      failures++;
      $display("FAIL single_hold got=ph%0d ch%0d exp=ph40 ch2",
               ph_phase[17:12], cur_ch);
    end
    checks++;
    if (drop_bad != 0 || ph_fire !== 7'd0) begin
      failures++;
      $display("FAIL single_drop got=%0d/%h exp=0/00",
               drop_bad, ph_fire);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    vme_wr(3, 7);
    wait_quiet(100, ok);
    checks++;
    if (!ok || cur_ch !== 3'd3) begin
      failures++;
      $display("FAIL rr_setup got=ok%0d ch%0d exp=ok1 ch3", ok, cur_ch);
    end
    clear_log();
    vme_wr(5, 21);
    vme_wr(3, 33);
    vme_wr(0, 12);
    wait_quiet(200, ok);
    checks++;
    if (!ok || order.size() != 3) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=3", order.size());
    end
    checks++;
    if (order[0] != 5 || order[1] != 0 || order[2] != 3) begin
      failures++;
      $display("FAIL rr_order got=%0d,%0d,%0d exp=5,0,3",
               order[0], order[1], order[2]);
    end
    checks++;
    if (ph_at[0] != 21 || ph_at[1] != 12 || ph_at[2] != 33) begin
      failures++;
      $display("FAIL rr_phase got=%0d,%0d,%0d exp=21,12,33",
               ph_at[0], ph_at[1], ph_at[2]);
    end
    checks++;
    if (onehot_bad != 0 || drop_bad != 0) begin
      failures++;
      $display("FAIL rr_onehot got=%0d/%0d exp=0/0",
               onehot_bad, drop_bad);
    end
  endtask

  task automatic test_rewrite();
    bit ok;
    int n;
    clear_log();
    vme_wr(1, 10);
    n = 0;
    while (!ph_busy[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vme_wr(1, 20);
    checks++;
    if (ph_phase[11:6] !== 6'd10 || pending !== 7'h02) begin
      failures++;
      $display("FAIL rewrite_hold got=ph%0d p%h exp=ph10 p02",
               ph_phase[11:6], pending);
    end
    wait_quiet(200, ok);
    checks++;
    if (!ok || order.size() != 2 || order[0] != 1 || order[1] != 1) begin
      failures++;
      $display("FAIL rewrite_runs got=n%0d exp=2 runs of ch1",
               order.size());
    end
    checks++;
    if (ph_at[0] != 10 || ph_at[1] != 20) begin
      failures++;
      $display("FAIL rewrite_phase got=%0d,%0d exp=10,20",
               ph_at[0], ph_at[1]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    clear_log();
    dead[4] = 1'b1;
    vme_wr(4, 5);
    n = 0;
    while (!ph_fire[4] && n < 20) begin
      @(negedge clk);
      n++;
    end
    wr_en    = 1'b1;
    wr_ch    = 3'd6;
    wr_phase = 6'd9;
    n = 0;
    while (!tmo_err[4] && n < 5000) begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
    end
    wr_en = 1'b0;
    checks++;
    if (n != 4097) begin
      failures++;
      $display("FAIL tmo_cycles got=%0d exp=4097", n);
    end
    checks++;
    if (tmo_err !== 7'h10 || ph_fire !== 7'd0 || sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_state got=e%h f%h b%b exp=e10 f00 b0",
               tmo_err, ph_fire, sched_busy);
    end
    checks++;
    if (pending !== 7'h40) begin
      failures++;
      $display("FAIL tmo_pend got=%h exp=40", pending);
    end
    wait_quiet(100, ok);
    dead[4] = 1'b0;
    checks++;
    if (!ok || order.size() != 2 || order[1] != 6 || ph_at[1] != 9) begin
      failures++;
      $display("FAIL tmo_next got=n%0d ch%0d ph%0d exp=n2 ch6 ph9",
               order.size(), order[1], ph_at[1]);
    end
    checks++;
    if (tmo_err !== 7'h10) begin
      failures++;
      $display("FAIL tmo_sticky got=%h exp=10", tmo_err);
    end
  endtask

  task automatic test_ignore();
    vme_wr(7, 11);
    repeat (3) @(negedge clk);
    checks++;
    if (pending !== 7'd0 || sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_ch7 got=p%h b%b exp=p00 b0",
               pending, sched_busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    vme_wr(6, 50);
    n = 0;
    while (!ph_busy[6] && n < 50) begin
      @(negedge clk);
      n++;
    end
    vme_wr(0, 3);
    checks++;
    if (ph_fire !== 7'h40 || pending !== 7'h01) begin
      failures++;
      $display("FAIL rmid_pre got=f%h p%h exp=f40 p01",
               ph_fire, pending);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ph_fire, pending, tmo_err, sched_busy} !== 22'd0) begin
      failures++;
      $display("FAIL rmid_flags got=%h exp=0",
               {ph_fire, pending, tmo_err, sched_busy});
    end
    checks++;
    if (cur_ch !== 3'd6 || ph_phase !== 42'd0) begin
      failures++;
      $display("FAIL rmid_ch got=ch%0d ph%h exp=ch6 ph0",
               cur_ch, ph_phase);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef PHASER_SCHED_AUTOLOAD_EN
  task automatic test_autoload();
    bit ok;
    rst_n    = 1'b0;
    lock_tmb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (100) @(negedge clk);
    checks++;
    if (pending !== 7'd0 || sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL al_wait got=p%h exp=00", pending);
    end
    lock_tmb = 1'b1;
    vme_wr(3, 60);
    checks++;
    if (pending !== 7'h7F) begin
      failures++;
      $display("FAIL al_pend got=%h exp=7f", pending);
    end
    wait_quiet(300, ok);
    checks++;
    if (!ok || order.size() != 7) begin
      failures++;
      $display("FAIL al_count got=%0d exp=7", order.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (order[i] != i || ph_at[i] != ((i == 3) ? 60 : 3*i + 1)) begin
        failures++;
        $display("FAIL al_run%0d got=ch%0d ph%0d exp=ch%0d ph%0d", i,
                 order[i], ph_at[i], i, (i == 3) ? 60 : 3*i + 1);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (pending !== 7'd0 || sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL al_once got=p%h exp=00", pending);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = 3'd0;
    wr_phase = 6'd0;
    fire_q   = 7'd0;
    sm_q     = 21'd0;
    for (int i = 0; i < 7; i++) dead[i] = 1'b0;
`ifdef PHASER_SCHED_AUTOLOAD_EN
    lock_tmb = 1'b0;
    for (int i = 0; i < 7; i++)
      autoload_phase[6*i +: 6] = 6'(3*i + 1);
`endif
    clear_log();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_rewrite();
    test_timeout();
    test_ignore();
    test_reset_mid();
`ifdef PHASER_SCHED_AUTOLOAD_EN
    test_autoload();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phaser_sched.md
Name: phaser_sched

Overview:
- Scheduler for the bank of DCM digital phase-shift state machines: ALCT rx/tx and CFEB0-4 clock phases, one phaser instance per channel.
- Holds a VME-written target phase per channel and raises a per-channel pending flag on each write.
- Sequences the phaser fire/unfire handshake for one channel at a time, choosing round-robin among pending channels.
- Detects hung phasers by timeout. Shifts never run concurrently, so a VME readback shows a single coherent busy channel.

Parameters:
- NCH, 7, number of phaser channels.
- MXCH, 3, channel index width (must satisfy 2^MXCH >= NCH).
- MXPHASE, 6, phase width per channel.
- MXTMO, 12, timeout counter width; timeout occurs after 2^MXTMO-1 cycles in one wait state.

Ports:
- clock  in  1  40MHz TMB clock 1x.
- global_reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  VME write strobe for a target phase, 1 cycle.
- wr_ch  in  MXCH  channel being written.
- wr_phase  in  MXPHASE  target phase value.
- ph_busy  in  NCH  busy output of each phaser.
- ph_sm_vec  in  3*NCH  dps_sm_vec of each phaser; channel i occupies bits [3i+2:3i]. Value 6 = unfire state.
- ph_fire  out  NCH  fire to each phaser, one-hot or zero.
- ph_phase  out  NCH*MXPHASE  phase to each phaser, held stable while that phaser runs.
- sched_busy  out  1  scheduler is not idle.
- cur_ch  out  MXCH  channel in service; last served channel when idle.
- pending  out  NCH  channels awaiting service.
- tmo_err  out  NCH  sticky timeout flags; cleared only by reset.

Behaviour:
- Reset values: ph_fire=0, ph_phase=all 0, pending=0, tmo_err=0, cur_ch=NCH-1, sched_busy=0, state=idle. Target registers reset to 0.
- Write: wr_en with wr_ch<NCH loads target[wr_ch] and sets pending[wr_ch] at the next edge. wr_ch>=NCH is ignored.
- Write during service, same channel: target updates; ph_phase[wr_ch] does not change; pending is set again, so the channel re-runs after the current shift.
- Arbitration: round-robin. Search from cur_ch+1 with wrap-around; the first pending channel wins. Single-cycle decision.
- State idle: if pending!=0, go to arb.
- State arb: latch the winner into cur_ch; copy ph_phase[cur_ch] <= target[cur_ch]; clear pending[cur_ch]. If a write to the same channel lands in this cycle, set wins over clear. Go to fire.
- State fire: assert ph_fire[cur_ch] (registered; first high at the fire-state edge). Go to wait_busy.
- State wait_busy: wait for ph_busy[cur_ch]=1, then go to wait_done.
- State wait_done: wait for ph_sm_vec[cur_ch]==6, then drop ph_fire and go to wait_idle.
- State wait_idle: wait for ph_busy[cur_ch]=0, then go to idle.
- Back-to-back service: idle to the next arb costs 1 cycle.
- Minimum service time: about 6 cycles plus the phaser's stepping time.
- Timeout: the counter clears on every state change. If it saturates in wait_busy, wait_done or wait_idle:
  - set tmo_err[cur_ch];
  - drop ph_fire;
  - go to idle.
  - No retry; pending stays as it is (a later write re-requests).
- sched_busy = (state!=idle), registered.
- Reset mid-operation: all outputs return to their reset values next cycle. A phaser whose fire drops mid-shift completes its shift on its own; that is acceptable.

Optional Feature:
- Macro: PHASER_SCHED_AUTOLOAD_EN.
- Defined:
  - Extra inputs lock_tmb (1 bit) and autoload_phase (NCH*MXPHASE bits), the PROM default phases.
  - After reset, the first cycle with lock_tmb=1 loads every target from autoload_phase and sets pending to all ones, exactly once per reset.
  - A VME write in the same cycle overrides its channel.
- Undefined: the extra ports are absent; targets come only from VME writes.

Decomposition:
- Shared package phaser_pkg:
  - state encoding constants;
  - PH_SM_UNFIRE=3'd6;
  - default MXPHASE and MXCH.
- One natural sub-module, phaser_rr_arb: combinational round-robin priority encoder. Inputs pending and cur_ch; outputs winner index and valid.

Test Plan:
1. Write ch2 = 40, phaser model goes busy 1 cycle after fire and reaches sm_vec=6 5 cycles later -> ph_phase[2]=40, ph_fire[2] high until sm_vec=6, pending[2] clears in arb, sched_busy returns to 0.
2. Write ch0, ch3 and ch5 in the same VME burst with cur_ch=3 -> service order ch5, ch0, ch3; no fire overlap; ph_fire always one-hot or zero.
3. Write ch1 = 10, then ch1 = 20 while ch1 is in wait_done -> ph_phase[1] stays 10 through the first run, then ch1 runs again with 20.
4. ch4 model never asserts busy -> after 4095 cycles tmo_err[4]=1, ph_fire=0, scheduler returns to idle and then serves the next pending channel.
5. Assert global_reset_n=0 during wait_done on ch6 -> next cycle ph_fire=0, pending=0, tmo_err=0, cur_ch=6 (NCH-1).
6. With PHASER_SCHED_AUTOLOAD_EN defined, hold lock_tmb=0 for 100 cycles then raise it -> pending=7'h7F, all 7 channels served in order ch0 to ch6, autoload happens only once.
